// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adder_pkg
// Description : Shared types and constants for the pipelined adder front end.
//               Holds the operand stager state encoding, the operand count and
//               the default operand width used by the stager and the adder.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  // Number of operands collected per adder job.
  localparam int ADDER_OPERANDS = 3;

  // Default operand width shared by stager and adder datapath.
  localparam int N_DEFAULT = 8;

  // Stager FSM states; 3-bit encoding leaves two codes unused (6, 7).
  typedef enum logic [2:0] {
    LOAD0     = 3'd0,
    LOAD1     = 3'd1,
    LOAD2     = 3'd2,
    FIRE      = 3'd3,
    WAIT_RUN  = 3'd4,
    WAIT_DONE = 3'd5
  } stager_state_t;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/operand_stager.sv
`default_nettype none
// ============================================================================
// Module      : operand_stager
// Description : Input stage of the pipelined adder. Accepts three N-bit
//               operands over a valid/ready stream, holds them on op_x/op_y/
//               op_z, pulses GO for one cycle and then blocks input until the
//               adder controller has finished its EN sequence. If EN does not
//               rise within TIMEOUT cycles of GO, the job is abandoned and the
//               sticky err flag is raised.
// Ports       : clk       - clock, all state changes on the rising edge
//               reset     - synchronous active-high reset
//               in_data   - operand word (N bits)
//               in_valid  - in_data valid
//               in_ready  - stager can accept in_data this cycle
//               op_x/y/z  - held first/second/third operand (N bits each)
//               GO        - one-cycle start pulse to the adder controller
//               EN        - controller enable, high during its compute cycles
//               busy      - high from the GO cycle until back in LOAD0
//               err       - sticky timeout flag, cleared by reset or next GO
//               The controller's active-low reset is ~reset, supplied at the
//               integration level from the same source.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_stager
  import adder_pkg::*;
#(
  parameter int N       = N_DEFAULT,
  parameter int TIMEOUT = 7          // must be >= 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] op_x,
  output logic [N-1:0] op_y,
  output logic [N-1:0] op_z,
  output logic         GO,
  input  logic         EN,
  output logic         busy,
  output logic         err
);

  localparam int            CW         = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

  stager_state_t r_state;
  stager_state_t w_next_state;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_err;
  logic          w_err_next;

  logic [N-1:0]  r_op_x;
  logic [N-1:0]  r_op_y;
  logic [N-1:0]  r_op_z;

  logic          w_cap_x;
  logic          w_cap_y;
  logic          w_cap_z;
  logic          w_in_ready;
  logic          w_go;
  logic          w_busy;

  // --------------------------------------------------------------------------
  // Next-state and Moore output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    w_cap_x      = 1'b0;
    w_cap_y      = 1'b0;
    w_cap_z      = 1'b0;
    w_in_ready   = 1'b0;
    w_go         = 1'b0;
    w_busy       = 1'b0;

    case (r_state)
      // in_ready is 1 in every LOAD state, so in_valid alone marks a transfer.
      LOAD0: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_cap_x      = 1'b1;
          w_next_state = LOAD1;
        end
      end

      LOAD1: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_cap_y      = 1'b1;
          w_next_state = LOAD2;
        end
      end

      LOAD2: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_cap_z      = 1'b1;
          w_next_state = FIRE;
        end
      end

      // A new job clears any earlier timeout and restarts the watchdog.
      FIRE: begin
        w_go         = 1'b1;
        w_busy       = 1'b1;
        w_err_next   = 1'b0;
        w_cnt_next   = '0;
        w_next_state = WAIT_RUN;
      end

      // The watchdog covers only the wait for EN to rise; r_cnt counts the
      // WAIT_RUN cycles already spent, so the abort happens on the TIMEOUT-th.
      WAIT_RUN: begin
        w_busy = 1'b1;
        if (EN) begin
          w_next_state = WAIT_DONE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == C_CNT_LAST) begin
            w_err_next   = 1'b1;
            w_next_state = LOAD0;
          end
        end
      end

      WAIT_DONE: begin
        w_busy = 1'b1;
        if (!EN) begin
          w_next_state = LOAD0;
        end
      end

      // Unused encodings recover to LOAD0 and present LOAD0 outputs meanwhile.
      default: begin
        w_in_ready   = 1'b1;
        w_next_state = LOAD0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, watchdog, error flag and operand registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_op_x  <= '0;
      r_op_y  <= '0;
      r_op_z  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      if (w_cap_x) r_op_x <= in_data;
      if (w_cap_y) r_op_y <= in_data;
      if (w_cap_z) r_op_z <= in_data;
    end
  end

  assign in_ready = w_in_ready;
  assign GO       = w_go;
  assign busy     = w_busy;
  assign err      = r_err;
  assign op_x     = r_op_x;
  assign op_y     = r_op_y;
  assign op_z     = r_op_z;

endmodule : operand_stager
`default_nettype wire

// File: tb/tb_operand_stager.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_stager
// Description : Self-checking bench for operand_stager. Expected operand
//               triples are queued when a job is streamed in and compared
//               when GO appears; a behavioural controller answers GO with a
//               three-cycle EN burst.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_stager;

  localparam int N       = 8;
  localparam int TIMEOUT = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] op_x;
  logic [N-1:0] op_y;
  logic [N-1:0] op_z;
  logic         GO;
  logic         EN;
  logic         busy;
  logic         err;

  int           checks = 0;
  int           errors = 0;
  int           go_count = 0;
  bit           ctrl_on = 1'b1;
  logic [23:0]  exp_q[$];
  logic [7:0]   held_x = 8'h00;
  logic [7:0]   held_y = 8'h00;
  logic [7:0]   held_z = 8'h00;

  operand_stager #(
    .N       (N),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_x     (op_x),
    .op_y     (op_y),
    .op_z     (op_z),
    .GO       (GO),
    .EN       (EN),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one word and hold it until the stager has taken it.
  // Called just after a rising edge; returns just after the transfer edge.
  task automatic send(input logic [7:0] d);
    int n;
    n        = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Returns on the falling edge of the first cycle with in_ready high.
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Behavioural adder controller: EN high for 3 cycles starting the cycle
  // after GO.
  initial begin
    EN = 1'b0;
    forever begin
      @(negedge clk);
      if (GO === 1'b1 && ctrl_on) begin
        @(posedge clk);
        #1 EN = 1'b1;
        repeat (3) @(posedge clk);
        #1 EN = 1'b0;
      end
    end
  end

  // Scoreboard: pop on GO, and insist the operands stay put while busy.
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (GO === 1'b1) begin
          go_count++;
          if (exp_q.size() == 0) begin
            check("go_unexpected", 32'd1, 32'd0);
          end else begin
            e      = exp_q.pop_front();
            held_x = e[23:16];
            held_y = e[15:8];
            held_z = e[7:0];
            check("go_op_x", 32'(op_x), 32'(held_x));
            check("go_op_y", 32'(op_y), 32'(held_y));
            check("go_op_z", 32'(op_z), 32'(held_z));
          end
        end else if (busy === 1'b1) begin
          check("hold_op_x", 32'(op_x), 32'(held_x));
          check("hold_op_y", 32'(op_y), 32'(held_y));
          check("hold_op_z", 32'(op_z), 32'(held_z));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          b;
    logic        en_last, en_prev, rdy_last;
    logic        pat_v [6];
    logic [7:0]  pat_d [3];
    int          k;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_go",       32'(GO),       32'd0);
    check("rst_err",      32'(err),      32'd0);
    check("rst_ops",      {8'h00, op_x, op_y, op_z}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back stream, GO timing, busy length and ready return
    exp_q.push_back(24'h123456);
    send(8'h12);
    send(8'h34);
    send(8'h56);
    in_valid = 1'b0;
    @(negedge clk);
    check("t2_go",       32'(GO),       32'd1);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t2_go_width", 32'(GO),       32'd0);
    check("t2_busy_c1",  32'(busy),     32'd1);
    check("t3_en_c1",    32'(EN),       32'd1);
    b        = 2;
    en_last  = EN;
    en_prev  = EN;
    rdy_last = in_ready;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      b++;
      en_prev  = en_last;
      en_last  = EN;
      rdy_last = in_ready;
    end
    check("t3_busy_len",    32'(b),        32'd5);
    check("t3_ready_back",  32'(in_ready), 32'd1);
    check("t3_en_fell",     32'(en_last),  32'd0);
    check("t3_en_before",   32'(en_prev),  32'd1);
    check("t3_ready_at_fall", 32'(rdy_last), 32'd0);
    @(posedge clk);
    #1;

    // in_valid held with 8'hFF while busy: nothing must be captured
    exp_q.push_back(24'hA1B2C3);
    send(8'hA1);
    send(8'hB2);
    send(8'hC3);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_ready();
    check("t6_keep_x", 32'(op_x), 32'h0A1);
    check("t6_keep_y", 32'(op_y), 32'h0B2);
    check("t6_keep_z", 32'(op_z), 32'h0C3);
    @(posedge clk);
    #1;

    // in_valid gaps 1,0,0,1,0,1
    pat_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    pat_d = '{8'h21, 8'h43, 8'h65};
    exp_q.push_back(24'h214365);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat_v[i];
      if (pat_v[i]) begin
        in_data = pat_d[k];
        k++;
      end else begin
        in_data = 8'hEE;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("t4_go", 32'(GO), 32'd1);
    wait_ready();
    @(posedge clk);
    #1;

    // Timeout: controller silent after GO
    ctrl_on = 1'b0;
    exp_q.push_back(24'h5A6B7C);
    send(8'h5A);
    send(8'h6B);
    send(8'h7C);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_go", 32'(GO), 32'd1);
    repeat (TIMEOUT) @(negedge clk);
    check("t5_err_pre",  32'(err),  32'd0);
    check("t5_busy_pre", 32'(busy), 32'd1);
    @(negedge clk);
    check("t5_err_set",  32'(err),      32'd1);
    check("t5_busy_off", 32'(busy),     32'd0);
    check("t5_ready",    32'(in_ready), 32'd1);
    ctrl_on = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(24'h0A0B0C);
    send(8'h0A);
    send(8'h0B);
    send(8'h0C);
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_go2",      32'(GO),  32'd1);
    check("t5_err_held", 32'(err), 32'd1);
    @(negedge clk);
    check("t5_err_clr",  32'(err), 32'd0);
    wait_ready();
    @(posedge clk);
    #1;

    // Reset in the middle of WAIT_DONE
    exp_q.push_back(24'h111213);
    send(8'h11);
    send(8'h12);
    send(8'h13);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t1_busy_pre",  32'(busy),     32'd1);
    check("t1_ready_pre", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t1_in_ready", 32'(in_ready), 32'd1);
    check("t1_busy",     32'(busy),     32'd0);
    check("t1_go",       32'(GO),       32'd0);
    check("t1_ops",      {8'h00, op_x, op_y, op_z}, 32'd0);
    repeat (3) @(negedge clk);
    check("t1_en_ignored", 32'(busy), 32'd0);

    check("go_total", 32'(go_count),     32'd6);
    check("q_empty",  32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_operand_stager
`default_nettype wire
